// File: rtl/ibex_alu_pext_shift_seq_pkg.sv
// Shared definitions for the iterative packed-SIMD shift unit.
// Holds the FSM state codes, lane-width select codes, lane counts and a small
// helper that turns the decoded width controls into a width select.
package ibex_alu_pext_shift_seq_pkg;

  // FSM state encoding
  typedef logic [1:0] pext_shift_state_t;
  localparam pext_shift_state_t PEXT_ST_IDLE = 2'd0;
  localparam pext_shift_state_t PEXT_ST_CALC = 2'd1;
  localparam pext_shift_state_t PEXT_ST_DONE = 2'd2;

  // Lane width select codes
  localparam logic [1:0] PEXT_W8  = 2'd0;
  localparam logic [1:0] PEXT_W16 = 2'd1;
  localparam logic [1:0] PEXT_W32 = 2'd2;

  // Number of lanes in a 32-bit word for the narrow widths
  localparam int unsigned PEXT_LANES8  = 4;
  localparam int unsigned PEXT_LANES16 = 2;

  // The 32-bit lane wins when both width bits are set; neither bit means 16-bit lanes
  function automatic logic [1:0] pext_decode_width(input logic width8, input logic width32);
    if (width32) begin
      return PEXT_W32;
    end else if (width8) begin
      return PEXT_W8;
    end
    return PEXT_W16;
  endfunction

endpackage

// File: rtl/ibex_alu_pext_shift_seq_if.sv
// Request/response bundle between the EX-stage controller (master) and the
// shift unit (slave).
//   request : valid_i/ready_o, operand_a_i, operand_b_i and decoded controls
//   response: valid_o/ready_i, result_o
//   misc    : kill_i flush, ov_clr_i sticky clear, ov_o sticky saturation flag
interface ibex_alu_pext_shift_seq_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        width8_i;
  logic        width32_i;
  logic        signed_i;
  logic        shift_left_i;
  logic        rounding_i;
  logic        sat_i;
  logic        kill_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        ov_clr_i;
  logic        ov_o;

  modport slave (
    input  valid_i, operand_a_i, operand_b_i, width8_i, width32_i, signed_i,
           shift_left_i, rounding_i, sat_i, kill_i, ready_i, ov_clr_i,
    output ready_o, valid_o, result_o, ov_o
  );

  modport master (
    output valid_i, operand_a_i, operand_b_i, width8_i, width32_i, signed_i,
           shift_left_i, rounding_i, sat_i, kill_i, ready_i, ov_clr_i,
    input  ready_o, valid_o, result_o, ov_o
  );
endinterface

// File: rtl/ibex_alu_pext_lane_shifter.sv
// Combinational single-lane shifter for 8/16/32-bit lanes.
//   data_i     lane value in the low bits (upper bits ignored)
//   amount_i   shift amount; only the bits meaningful for the lane width are used
//   width_i    lane width select
//   signed_i, left_i, rounding_i, sat_i  operation controls
//   result_o   lane result in the low bits, zero above the lane
//   sat_o      the left shift was clamped
module ibex_alu_pext_lane_shifter
  import ibex_alu_pext_shift_seq_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [4:0]  amount_i,
  input  logic [1:0]  width_i,
  input  logic        signed_i,
  input  logic        left_i,
  input  logic        rounding_i,
  input  logic        sat_i,
  output logic [31:0] result_o,
  output logic        sat_o
);

  logic [5:0]  lane_bits;
  logic [4:0]  amt;
  logic        sign_bit;
  logic        round_bit;
  logic        fits;
  logic [63:0] lane_mask;
  logic [63:0] ext;
  logic [63:0] shr;
  logic [63:0] shl;
  logic [63:0] sh_hi;
  logic [63:0] rnd_src;
  logic [63:0] res;

  // The lane is widened to 64 bits so a left shift keeps every bit it moves
  // out of the lane; overflow is then a plain compare on the upper bits.
  always_comb begin
    lane_bits = 6'd32;
    amt       = amount_i;
    case (width_i)
      PEXT_W8: begin
        lane_bits = 6'd8;
        amt       = {2'b00, amount_i[2:0]};
      end
      PEXT_W16: begin
        lane_bits = 6'd16;
        amt       = {1'b0, amount_i[3:0]};
      end
      default: ;
    endcase

    lane_mask = (64'd1 << lane_bits) - 64'd1;
    sign_bit  = data_i[5'(lane_bits - 6'd1)];
    ext       = {32'd0, data_i} & lane_mask;
    if (signed_i && sign_bit) begin
      ext = ext | ~lane_mask;
    end

    // Right shift; the rounding increment is the last bit shifted out
    shr       = $unsigned($signed(ext) >>> amt);
    rnd_src   = ext >> (amt - 5'd1);
    round_bit = rounding_i && (amt != 5'd0) && rnd_src[0];

    // Left shift fits when everything above the lane is pure sign (signed) or zero
    shl = ext << amt;
    if (signed_i) begin
      sh_hi = $unsigned($signed(shl) >>> (lane_bits - 6'd1));
      fits  = (sh_hi == 64'd0) || (sh_hi == {64{1'b1}});
    end else begin
      sh_hi = shl >> lane_bits;
      fits  = (sh_hi == 64'd0);
    end

    sat_o = 1'b0;
    if (amt == 5'd0) begin
      res = ext;
    end else if (!left_i) begin
      res = shr + {63'd0, round_bit};
    end else if (sat_i && !fits) begin
      sat_o = 1'b1;
      if (!signed_i) begin
        res = lane_mask;
      end else if (sign_bit) begin
        res = 64'd1 << (lane_bits - 6'd1);
      end else begin
        res = lane_mask >> 1;
      end
    end else begin
      res = shl;
    end

    result_o = 32'(res & lane_mask);
  end

endmodule

// File: rtl/ibex_alu_pext_shift_seq.sv
// Iterative packed-SIMD shift/round/saturate unit. One lane is processed per
// cycle through a shared lane shifter, then the result is held until taken.
//   clk_i, rst_i  clock and asynchronous active-high reset
//   bus           slave side of the request/response bundle
module ibex_alu_pext_shift_seq
  import ibex_alu_pext_shift_seq_pkg::*;
(
  input logic                        clk_i,
  input logic                        rst_i,
  ibex_alu_pext_shift_seq_if.slave   bus
);

  pext_shift_state_t state_q;
  logic [1:0]        cnt_q;
  logic [31:0]       a_q;
  logic [4:0]        amt_q;
  logic [1:0]        width_q;
  logic              signed_q;
  logic              left_q;
  logic              rnd_q;
  logic              sat_q;
  logic [31:0]       result_q;
  logic              op_sat_q;
  logic              ov_q;

  logic [4:0]        lane_off;
  logic [31:0]       lane_mask;
  logic [1:0]        last_cnt;
  logic [31:0]       lane_in;
  logic [31:0]       lane_res;
  logic              lane_sat;
  logic              accept;
  logic              handshake;

  assign accept    = (state_q == PEXT_ST_IDLE) && bus.valid_i && !bus.kill_i;
  assign handshake = (state_q == PEXT_ST_DONE) && bus.ready_i && !bus.kill_i;

  // Select the current lane out of the latched operand
  always_comb begin
    lane_off  = 5'd0;
    lane_mask = 32'hFFFF_FFFF;
    last_cnt  = 2'd0;
    case (width_q)
      PEXT_W8: begin
        lane_off  = {cnt_q, 3'b000};
        lane_mask = 32'h0000_00FF;
        last_cnt  = 2'(PEXT_LANES8 - 1);
      end
      PEXT_W16: begin
        lane_off  = {cnt_q[0], 4'b0000};
        lane_mask = 32'h0000_FFFF;
        last_cnt  = 2'(PEXT_LANES16 - 1);
      end
      default: ;
    endcase
    lane_in = a_q >> lane_off;
  end

  ibex_alu_pext_lane_shifter u_lane (
    .data_i     (lane_in),
    .amount_i   (amt_q),
    .width_i    (width_q),
    .signed_i   (signed_q),
    .left_i     (left_q),
    .rounding_i (rnd_q),
    .sat_i      (sat_q),
    .result_o   (lane_res),
    .sat_o      (lane_sat)
  );

  // FSM, operand latch and lane-by-lane write-back. A kill during CALC drops
  // the lane of that cycle, so the result keeps whatever lanes were done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= PEXT_ST_IDLE;
      cnt_q    <= 2'd0;
      a_q      <= 32'd0;
      amt_q    <= 5'd0;
      width_q  <= PEXT_W8;
      signed_q <= 1'b0;
      left_q   <= 1'b0;
      rnd_q    <= 1'b0;
      sat_q    <= 1'b0;
      result_q <= 32'd0;
      op_sat_q <= 1'b0;
    end else begin
      case (state_q)
        PEXT_ST_IDLE: begin
          if (accept) begin
            a_q      <= bus.operand_a_i;
            amt_q    <= bus.operand_b_i[4:0];
            width_q  <= pext_decode_width(bus.width8_i, bus.width32_i);
            signed_q <= bus.signed_i;
            left_q   <= bus.shift_left_i;
            rnd_q    <= bus.rounding_i;
            sat_q    <= bus.sat_i;
            cnt_q    <= 2'd0;
            op_sat_q <= 1'b0;
            state_q  <= PEXT_ST_CALC;
          end
        end
        PEXT_ST_CALC: begin
          if (bus.kill_i) begin
            state_q <= PEXT_ST_IDLE;
          end else begin
            result_q <= (result_q & ~(lane_mask << lane_off)) |
                        ((lane_res & lane_mask) << lane_off);
            if (lane_sat) begin
              op_sat_q <= 1'b1;
            end
            if (cnt_q == last_cnt) begin
              state_q <= PEXT_ST_DONE;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        PEXT_ST_DONE: begin
          if (bus.kill_i || bus.ready_i) begin
            state_q <= PEXT_ST_IDLE;
          end
        end
        default: state_q <= PEXT_ST_IDLE;
      endcase
    end
  end

  // Sticky saturation flag; a set on the handshake beats a same-cycle clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ov_q <= 1'b0;
    end else if (handshake && op_sat_q) begin
      ov_q <= 1'b1;
    end else if (bus.ov_clr_i) begin
      ov_q <= 1'b0;
    end
  end

  assign bus.ready_o  = (state_q == PEXT_ST_IDLE);
  assign bus.valid_o  = (state_q == PEXT_ST_DONE);
  assign bus.result_o = result_q;
  assign bus.ov_o     = ov_q;

endmodule

// File: tb/tb_ibex_alu_pext_shift_seq.sv
// Testbench for ibex_alu_pext_shift_seq: directed scenarios with literal
// expectations followed by randomized traffic, all watched by a reference model.
module tb_ibex_alu_pext_shift_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ibex_alu_pext_shift_seq_if bus ();

  ibex_alu_pext_shift_seq dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  // One comparison: count it and report a mismatch
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: each lane is turned into an integer, shifted by
  // multiplication/floor-division, range-checked and clamped, then repacked.
  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b,
                                 input logic w8, input logic w32, input logic sg,
                                 input logic left, input logic rnd, input logic st,
                                 output logic [31:0] res, output logic sat_f,
                                 output int lanes);
    longint one = 1;
    longint u, v, r, lo, hi, m;
    int w, amt;
    w     = w32 ? 32 : (w8 ? 8 : 16);
    lanes = 32 / w;
    amt   = int'(b & 32'(w - 1));
    m     = (one << w) - 1;
    res   = 32'd0;
    sat_f = 1'b0;
    for (int i = 0; i < lanes; i++) begin
      u = longint'(a >> (i * w)) & m;
      v = (sg && u >= (one << (w - 1))) ? u - (one << w) : u;
      if (amt == 0) begin
        r = v;
      end else if (!left) begin
        r = rnd ? ((v + (one << (amt - 1))) >>> amt) : (v >>> amt);
      end else begin
        r  = v * (one << amt);
        lo = sg ? -(one << (w - 1)) : 0;
        hi = sg ? (one << (w - 1)) - 1 : m;
        if (st && (r < lo || r > hi)) begin
          sat_f = 1'b1;
          r     = (r < lo) ? lo : hi;
        end
      end
      res = res | (32'(r & m) << (i * w));
    end
  endfunction

  // Transaction-level view of the unit: idle, busy for a number of lane
  // cycles, or holding a finished result.
  int          m_phase;
  int          m_left;
  logic [31:0] m_exp;
  logic        m_sat;
  logic        m_ov;
  logic [31:0] m_res;
  logic        m_res_known;

  // Compare outputs with the model each cycle, then advance the model using
  // the inputs that the next rising edge will see.
  always @(negedge clk) begin
    int lanes;
    logic hs;
    if (rst) begin
      m_phase     = 0;
      m_ov        = 1'b0;
      m_res       = 32'd0;
      m_res_known = 1'b1;
    end else begin
      check_output("ready_o", 32'(bus.ready_o), 32'(m_phase == 0));
      check_output("valid_o", 32'(bus.valid_o), 32'(m_phase == 2));
      check_output("ov_o", 32'(bus.ov_o), 32'(m_ov));
      if (m_res_known) check_output("result_o", bus.result_o, m_res);

      hs = (m_phase == 2) && bus.ready_i && !bus.kill_i;
      case (m_phase)
        0: if (bus.valid_i && !bus.kill_i) begin
             ref_op(bus.operand_a_i, bus.operand_b_i, bus.width8_i, bus.width32_i,
                    bus.signed_i, bus.shift_left_i, bus.rounding_i, bus.sat_i,
                    m_exp, m_sat, lanes);
             m_left      = lanes;
             m_phase     = 1;
             m_res_known = 1'b0;
           end
        1: if (bus.kill_i) begin
             m_phase = 0;
           end else begin
             m_left--;
             if (m_left == 0) begin
               m_phase     = 2;
               m_res       = m_exp;
               m_res_known = 1'b1;
             end
           end
        default: if (bus.kill_i || bus.ready_i) m_phase = 0;
      endcase
      if (hs && m_sat) m_ov = 1'b1;
      else if (bus.ov_clr_i) m_ov = 1'b0;
    end
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until the accepting edge has passed
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic w8, input logic w32, input logic sg,
                                input logic left, input logic rnd, input logic st);
    int n = 0;
    while (!bus.ready_o && n < 20) begin
      tick();
      n++;
    end
    check_output("accept_ready", 32'(bus.ready_o), 32'd1);
    bus.operand_a_i  = a;
    bus.operand_b_i  = b;
    bus.width8_i     = w8;
    bus.width32_i    = w32;
    bus.signed_i     = sg;
    bus.shift_left_i = left;
    bus.rounding_i   = rnd;
    bus.sat_i        = st;
    bus.valid_i      = 1'b1;
    tick();
    bus.valid_i      = 1'b0;
    // Later operand changes must not disturb the accepted op
    bus.operand_a_i  = $urandom;
    bus.operand_b_i  = $urandom;
  endtask

  // Count edges until valid_o rises and check that count
  task automatic wait_valid(input int exp_lat, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.valid_o && n < 20);
    check_output(name, 32'(n), 32'(exp_lat));
  endtask

  task automatic take_result();
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
  endtask

  // Main sequence
  initial begin
    logic [31:0] r;
    logic        s;
    int          l;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.valid_i = 1'b0; bus.operand_a_i = '0; bus.operand_b_i = '0;
    bus.width8_i = 1'b0; bus.width32_i = 1'b0; bus.signed_i = 1'b0;
    bus.shift_left_i = 1'b0; bus.rounding_i = 1'b0; bus.sat_i = 1'b0;
    bus.kill_i = 1'b0; bus.ready_i = 1'b0; bus.ov_clr_i = 1'b0;

    // Pin the reference arithmetic to hand-worked values
    ref_op(32'h8001_0007, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, r, s, l);
    check_output("model_rnd16", r, 32'hC001_0004);
    ref_op(32'h407F_0180, 32'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, r, s, l);
    check_output("model_sat8", r, 32'h7F7F_0280);
    check_output("model_sat8_flag", 32'(s), 32'd1);
    ref_op(32'hF0F0_F0F0, 32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r, s, l);
    check_output("model_srl8", r, 32'h0F0F_0F0F);
    ref_op(32'h1234_5678, 32'hFFFF_FFE0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, r, s, l);
    check_output("model_amt0", r, 32'h1234_5678);

    tick();
    tick();
    rst = 1'b0;
    check_output("reset_ready", 32'(bus.ready_o), 32'd1);
    check_output("reset_valid", 32'(bus.valid_o), 32'd0);
    check_output("reset_result", bus.result_o, 32'd0);
    check_output("reset_ov", 32'(bus.ov_o), 32'd0);

    // 16-bit signed rounding right shift
    apply_stimulus(32'h8001_0007, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_valid(2, "lat16");
    check_output("rnd16", bus.result_o, 32'hC001_0004);
    take_result();
    check_output("rnd16_ov", 32'(bus.ov_o), 32'd0);

    // 8-bit signed saturating left shift
    apply_stimulus(32'h407F_0180, 32'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_valid(4, "lat8");
    check_output("sat8", bus.result_o, 32'h7F7F_0280);
    take_result();
    check_output("sat8_ov", 32'(bus.ov_o), 32'd1);

    // 32-bit unsigned saturation, sticky clear, then set beating clear
    apply_stimulus(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_valid(1, "lat32");
    check_output("usat32", bus.result_o, 32'hFFFF_FFFF);
    take_result();
    check_output("usat32_ov", 32'(bus.ov_o), 32'd1);
    bus.ov_clr_i = 1'b1;
    tick();
    bus.ov_clr_i = 1'b0;
    check_output("ov_cleared", 32'(bus.ov_o), 32'd0);
    apply_stimulus(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_valid(1, "lat32b");
    bus.ready_i  = 1'b1;
    bus.ov_clr_i = 1'b1;
    tick();
    bus.ready_i  = 1'b0;
    bus.ov_clr_i = 1'b0;
    check_output("ov_set_wins", 32'(bus.ov_o), 32'd1);

    // 8-bit logical right shift with the consumer stalling
    apply_stimulus(32'hF0F0_F0F0, 32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_valid(4, "lat8b");
    for (int i = 0; i < 3; i++) begin
      check_output("stall_valid", 32'(bus.valid_o), 32'd1);
      check_output("stall_result", bus.result_o, 32'h0F0F_0F0F);
      check_output("stall_ready", 32'(bus.ready_o), 32'd0);
      tick();
    end
    take_result();
    check_output("after_hs_ready", 32'(bus.ready_o), 32'd1);

    // Kill while the second 8-bit lane is being computed
    apply_stimulus(32'h1122_3344, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    bus.kill_i = 1'b1;
    tick();
    bus.kill_i = 1'b0;
    check_output("kill_ready", 32'(bus.ready_o), 32'd1);
    check_output("kill_valid", 32'(bus.valid_o), 32'd0);
    check_output("kill_ov", 32'(bus.ov_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("kill_no_valid", 32'(bus.valid_o), 32'd0);
    end
    apply_stimulus(32'h1234_5678, 32'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_valid(1, "lat_after_kill");
    check_output("after_kill", bus.result_o, 32'h0123_4567);
    take_result();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.valid_i      = $urandom_range(0, 1);
      bus.operand_a_i  = $urandom;
      bus.operand_b_i  = $urandom;
      bus.width8_i     = $urandom_range(0, 1);
      bus.width32_i    = $urandom_range(0, 1);
      bus.signed_i     = $urandom_range(0, 1);
      bus.shift_left_i = $urandom_range(0, 1);
      bus.rounding_i   = $urandom_range(0, 1);
      bus.sat_i        = $urandom_range(0, 1);
      bus.kill_i       = ($urandom_range(0, 19) == 0);
      bus.ready_i      = ($urandom_range(0, 2) != 0);
      bus.ov_clr_i     = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.valid_i  = 1'b0;
    bus.ready_i  = 1'b0;
    bus.ov_clr_i = 1'b0;
    bus.kill_i   = 1'b1;
    tick();
    bus.kill_i   = 1'b0;

    // Asynchronous reset while a result is waiting and the flag is set
    apply_stimulus(32'h7F00_0000, 32'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_valid(4, "lat_pre_rst");
    take_result();
    check_output("pre_rst_ov", 32'(bus.ov_o), 32'd1);
    apply_stimulus(32'h0000_0003, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_valid(2, "lat_rst_op");
    #2;
    rst = 1'b1;
    #1;
    check_output("arst_valid", 32'(bus.valid_o), 32'd0);
    check_output("arst_ov", 32'(bus.ov_o), 32'd0);
    check_output("arst_ready", 32'(bus.ready_o), 32'd1);
    check_output("arst_result", bus.result_o, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
